// File: rtl/axe_clk_burst_gen.sv
// axe_clk_burst_gen: programmable high/low divided-clock generator, burst or free-run
module axe_clk_burst_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_low,
  input  logic [BURST_W-1:0] start_burst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               stop_req,
  output logic               div_clk_o,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               done_pulse,
  output logic               busy,
  output logic [BURST_W-1:0] periods_done
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t             state;
  logic [CNT_W-1:0]   h_len, l_len, cnt;
  logic [BURST_W-1:0] n_len;
  logic               stop_f;
  logic               last_period;
  assign start_ready = state == IDLE;
  // a live stop_req in the final LOW cycle still counts, so it is folded in with the sticky flag
  assign last_period = stop_f | stop_req | (n_len != '0 && periods_done == n_len - 1'b1);
  // phase sequencer: every output except start_ready is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      h_len        <= '0;
      l_len        <= '0;
      n_len        <= '0;
      cnt          <= '0;
      stop_f       <= 1'b0;
      div_clk_o    <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      done_pulse   <= 1'b0;
      busy         <= 1'b0;
      periods_done <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      done_pulse <= 1'b0;
      case (state)
        IDLE: if (start_valid) begin
          h_len        <= cfg_high == '0 ? CNT_W'(1) : cfg_high;
          l_len        <= cfg_low == '0 ? CNT_W'(1) : cfg_low;
          n_len        <= start_burst;
          periods_done <= '0;
          stop_f       <= 1'b0;
          cnt          <= CNT_W'(1);
          state        <= HIGH;
          div_clk_o    <= 1'b1;
          rise_pulse   <= 1'b1;
          busy         <= 1'b1;
        end
        HIGH: begin
          stop_f <= stop_f | stop_req;
          if (cnt == h_len) begin
            cnt        <= CNT_W'(1);
            state      <= LOW;
            div_clk_o  <= 1'b0;
            fall_pulse <= 1'b1;
          end else
            cnt <= cnt + 1'b1;
        end
        LOW: begin
          stop_f <= stop_f | stop_req;
          if (cnt == l_len) begin
            if (periods_done != '1)
              periods_done <= periods_done + 1'b1;
            cnt <= CNT_W'(1);
            if (last_period) begin
              state      <= IDLE;
              done_pulse <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state      <= HIGH;
              div_clk_o  <= 1'b1;
              rise_pulse <= 1'b1;
            end
          end else
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axe_clk_burst_gen.sv
// tb_axe_clk_burst_gen: scoreboard bench checking edge/done timing of the burst generator
module tb_axe_clk_burst_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_high = '0, cfg_low = '0, start_burst = '0;
  logic        start_valid = 1'b0, stop_req = 1'b0;
  logic        start_ready, div_clk_o, rise_pulse, fall_pulse, done_pulse, busy;
  logic [15:0] periods_done;
  logic        sv6 = 1'b0, stop6 = 1'b0;
  logic [3:0]  sb6 = '0;
  logic        ready6, div6, rise6, fall6, done6, busy6;
  logic [3:0]  pd6;
  int          cyc = 0;
  int          n_done6 = 0;
  int          total = 0, passed = 0;
  typedef struct {int kind; int at;} ev_t;
  ev_t         q[$];

  axe_clk_burst_gen dut (
    .clk(clk), .rst(rst), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .start_burst(start_burst), .start_valid(start_valid), .start_ready(start_ready),
    .stop_req(stop_req), .div_clk_o(div_clk_o), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .done_pulse(done_pulse), .busy(busy), .periods_done(periods_done)
  );

  axe_clk_burst_gen #(.CNT_W(16), .BURST_W(4)) dut6 (
    .clk(clk), .rst(rst), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .start_burst(sb6), .start_valid(sv6), .start_ready(ready6),
    .stop_req(stop6), .div_clk_o(div6), .rise_pulse(rise6),
    .fall_pulse(fall6), .done_pulse(done6), .busy(busy6), .periods_done(pd6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done6) n_done6 <= n_done6 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // pop one expected edge/done event for every pulse the DUT emits
  always @(negedge clk) begin
    int   k;
    ev_t  e;
    if (!rst && (rise_pulse || fall_pulse || done_pulse)) begin
      k = rise_pulse ? 1 : fall_pulse ? 2 : 3;
      if (q.size() == 0)
        chk("unexpected_event", k, 0);
      else begin
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.at);
        chk("div_level_at_event", {31'd0, div_clk_o}, (k == 1) ? 1 : 0);
      end
    end
  end

  task automatic push_burst(input int c0, input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      q.push_back('{1, c0 + p * (h + l)});
      q.push_back('{2, c0 + p * (h + l) + h});
    end
    q.push_back('{3, c0 + n * (h + l)});
  endtask

  task automatic start(input int h, input int l, input int n, output int c0);
    @(negedge clk);
    cfg_high    = 16'(h);
    cfg_low     = 16'(l);
    start_burst = 16'(n);
    start_valid = 1'b1;
    chk("start_ready_idle", {31'd0, start_ready}, 1);
    @(posedge clk);
    #1;
    c0          = cyc;
    start_valid = 1'b0;
  endtask

  task automatic waitcyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int c0, d0;
    repeat (2) @(negedge clk);
    chk("reset_div", {31'd0, div_clk_o}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_ready", {31'd0, start_ready}, 1);
    chk("reset_periods", {16'd0, periods_done}, 0);
    chk("reset_done", {31'd0, done_pulse}, 0);
    rst = 1'b0;
    // burst H=2 L=3 N=4
    start(2, 3, 4, c0);
    push_burst(c0, 2, 3, 4);
    waitcyc(c0 + 10);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_ready_busy", {31'd0, start_ready}, 0);
    waitcyc(c0 + 21);
    chk("t1_periods", {16'd0, periods_done}, 4);
    chk("t1_idle", {31'd0, busy}, 0);
    // zero lengths behave as 1/1
    start(0, 0, 3, c0);
    push_burst(c0, 1, 1, 3);
    waitcyc(c0 + 8);
    chk("t2_periods", {16'd0, periods_done}, 3);
    // free-run stopped mid HIGH of the third period
    start(4, 4, 0, c0);
    for (int p = 0; p < 3; p++) begin
      q.push_back('{1, c0 + p * 8});
      q.push_back('{2, c0 + p * 8 + 4});
    end
    q.push_back('{3, c0 + 24});
    waitcyc(c0 + 17);
    chk("t3_busy_before_stop", {31'd0, busy}, 1);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    waitcyc(c0 + 25);
    chk("t3_periods", {16'd0, periods_done}, 3);
    chk("t3_idle", {31'd0, busy}, 0);
    // start held valid across a burst, accepted in the done cycle
    start(1, 1, 2, c0);
    cfg_high    = 16'd3;
    cfg_low     = 16'd2;
    start_burst = 16'd1;
    start_valid = 1'b1;
    push_burst(c0, 1, 1, 2);
    push_burst(c0 + 5, 3, 2, 1);
    waitcyc(c0 + 1);
    chk("t4_ready_while_busy", {31'd0, start_ready}, 0);
    waitcyc(c0 + 5);
    start_valid = 1'b0;
    waitcyc(c0 + 11);
    chk("t4_periods", {16'd0, periods_done}, 1);
    chk("t4_idle", {31'd0, busy}, 0);
    // async reset mid HIGH
    start(6, 2, 1, c0);
    q.push_back('{1, c0});
    waitcyc(c0 + 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_div_async", {31'd0, div_clk_o}, 0);
    chk("t5_ready_async", {31'd0, start_ready}, 1);
    chk("t5_busy_async", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    waitcyc(cyc + 10);
    chk("t5_still_idle", {31'd0, busy}, 0);
    // 4-bit period counter saturation in free-run
    @(negedge clk);
    cfg_high = 16'd1;
    cfg_low  = 16'd1;
    sb6      = 4'd0;
    sv6      = 1'b1;
    @(posedge clk);
    #1;
    c0  = cyc;
    sv6 = 1'b0;
    waitcyc(c0 + 20);
    chk("t6_periods_10", {28'd0, pd6}, 10);
    waitcyc(c0 + 40);
    chk("t6_periods_sat", {28'd0, pd6}, 15);
    d0    = n_done6;
    stop6 = 1'b1;
    @(negedge clk);
    stop6 = 1'b0;
    waitcyc(c0 + 50);
    chk("t6_single_done", n_done6 - d0, 1);
    chk("t6_periods_final", {28'd0, pd6}, 15);
    chk("t6_idle", {31'd0, busy6}, 0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
